// File: rtl/i2s_tx_serializer_pkg.sv
// Shared audio types for the I2S transmit path.
// Frame geometry, stereo pair layout and word-select helper.
package i2s_tx_serializer_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;

  typedef struct packed {
    logic [I2S_SLOT_BITS-1:0] left;
    logic [I2S_SLOT_BITS-1:0] right;
  } stereo_t;

  // WS leads each slot's MSB by one BCK
  function automatic logic ws_for_bit(input logic [5:0] b);
    return (b >= 6'(I2S_SLOT_BITS - 1)) &&
           (b != 6'(I2S_FRAME_BITS - 1));
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: phase counter, registered BCK
// and a tick strobe on the cycle the phase wraps.
module i2s_bck_gen #(
  parameter int BCK_HALF = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic bck_o,
  output logic tick_o
);

  localparam int PW = $clog2(2 * BCK_HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * BCK_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(BCK_HALF);

  logic [PW-1:0] ph_q, ph_d;
  logic          bck_q;

  assign tick_o = (ph_q == PH_LAST);
  assign ph_d   = tick_o ? '0 : ph_q + PW'(1);
  assign bck_o  = bck_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q  <= '0;
      bck_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      bck_q <= (ph_d >= PH_HIGH);
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Parallel-to-I2S transmitter with one-pair holding buffer
// and optional 2x decimation of incoming sample pairs.
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int BCK_HALF  = 4,
  parameter int DATA_BITS = 24
) (
  input  logic                 AMCLK_i,
  input  logic                 ARST_i,
  input  logic [DATA_BITS-1:0] APSDATA_LEFT_i,
  input  logic [DATA_BITS-1:0] APSDATA_RIGHT_i,
  input  logic                 APDATA_VALID_i,
  input  logic                 downsample_2x_i,
  output logic                 I2S_BCK,
  output logic                 I2S_WS,
  output logic                 I2S_DATA,
  output logic                 UNDERFLOW_o,
  output logic                 OVERFLOW_o
);

  logic    tick;
  stereo_t in_pair;
  stereo_t pend_q, pend_d;
  stereo_t act_q, act_d;
  logic    pend_full_q, pend_full_d;
  logic    skip_q, skip_d;
  logic [5:0] b_q, b_d;
  logic    ws_q, ws_d;
  logic    data_q, data_d;
  logic    uf_q, uf_d;
  logic    of_q, of_d;
  logic    frame_start, accept, consume;
  logic [I2S_SLOT_BITS-1:0] word;
  logic [4:0] slot_bit;

  i2s_bck_gen #(
    .BCK_HALF(BCK_HALF)
  ) u_bck (
    .clk_i (AMCLK_i),
    .rst_i (ARST_i),
    .bck_o (I2S_BCK),
    .tick_o(tick)
  );

  assign in_pair.left  = I2S_SLOT_BITS'(APSDATA_LEFT_i);
  assign in_pair.right = I2S_SLOT_BITS'(APSDATA_RIGHT_i);

  always_comb begin
    frame_start = tick && (b_q == 6'(I2S_FRAME_BITS - 1));
    accept  = APDATA_VALID_i && (!downsample_2x_i || !skip_q);
    consume = frame_start && pend_full_q;
    skip_d  = downsample_2x_i &&
              (APDATA_VALID_i ? !skip_q : skip_q);

    // a same-cycle accept refills pending after the hand-off
    act_d       = consume ? pend_q : act_q;
    pend_d      = accept ? in_pair : pend_q;
    pend_full_d = accept || (pend_full_q && !consume);
    uf_d        = frame_start && !pend_full_q;
    of_d        = accept && pend_full_q && !consume;

    b_d      = tick ? b_q + 6'd1 : b_q;
    word     = b_d[5] ? act_d.right : act_d.left;
    slot_bit = b_d[4:0];
    ws_d     = ws_q;
    data_d   = data_q;
    if (tick) begin
      ws_d = ws_for_bit(b_d);
      if ({1'b0, slot_bit} < 6'(DATA_BITS)) begin
        data_d = word[5'(DATA_BITS - 1) - slot_bit];
      end else begin
        data_d = 1'b0;
      end
    end
  end

  always_ff @(posedge AMCLK_i) begin
    if (ARST_i) begin
      pend_q      <= '0;
      act_q       <= '0;
      pend_full_q <= 1'b0;
      skip_q      <= 1'b0;
      b_q         <= 6'(I2S_FRAME_BITS - 1);
      ws_q        <= 1'b0;
      data_q      <= 1'b0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_full_q <= pend_full_d;
      skip_q      <= skip_d;
      b_q         <= b_d;
      ws_q        <= ws_d;
      data_q      <= data_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
    end
  end

  assign I2S_WS      = ws_q;
  assign I2S_DATA    = data_q;
  assign UNDERFLOW_o = uf_q;
  assign OVERFLOW_o  = of_q;

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Parallel-to-I2S transmitter for the audio output path. It sits after the interpolation FIR collector and takes 24-bit stereo sample pairs, given as a one-cycle valid pulse, in the AMCLK domain. It generates BCK and WS as a clock master from AMCLK and shifts the samples out MSB-first in standard I2S framing (64 BCK per frame). A one-pair holding buffer decouples FIR output timing from frame timing. An optional 2× decimation drops every second input pair.

## Interface
- `BCK_HALF`, default 4: AMCLK cycles per BCK half-period. Must be ≥1. Frame = 128·`BCK_HALF` AMCLK cycles.
- `DATA_BITS`, default 24: sample width. Must be ≤32. Each slot is 32 BCK.
- `AMCLK_i` in 1: the only clock. Rising-edge.
- `ARST_i` in 1: reset, synchronous, active-high.
- `APSDATA_LEFT_i` in `DATA_BITS`: left sample, two's complement.
- `APSDATA_RIGHT_i` in `DATA_BITS`: right sample.
- `APDATA_VALID_i` in 1: one-cycle strobe. Both samples are valid in that cycle.
- `downsample_2x_i` in 1: when 1, accept only every second strobe.
- `I2S_BCK` out 1: bit clock, registered.
- `I2S_WS` out 1: word select. 0 = left, 1 = right. Registered.
- `I2S_DATA` out 1: serial data. Changes on BCK falling edge. Registered.
- `UNDERFLOW_o` out 1: one-cycle pulse when a frame starts with no new pair.
- `OVERFLOW_o` out 1: one-cycle pulse when a pending pair is overwritten.

## Operation
- **Phase counter** `ph`: 0..2·`BCK_HALF`−1, wraps.
  - `I2S_BCK` = 0 for `ph` < `BCK_HALF`, otherwise 1.
  - A falling edge is the cycle where `ph` wraps to 0. Call this a "tick".
- **Bit index** `b`: 0..63, increments each tick and wraps 63→0.
- **Frame start**: the tick where `b` wraps to 0. At frame start:
  - if pending is full: active ← pending, pending cleared;
  - else: active keeps its last pair, and `UNDERFLOW_o` pulses.
- **Outputs on each tick**, using the updated `b`:
  - `I2S_WS` = 1 for `b` in 31..62, else 0. WS therefore leads each slot's MSB by one BCK.
  - `I2S_DATA` = bit (`DATA_BITS`−1−`b`[4:0]) of active left (`b`[5]=0) or active right (`b`[5]=1) when `b`[4:0] < `DATA_BITS`, else 0.
- **Accept logic**:
  - Toggle `skip` flips on every strobe while `downsample_2x_i`=1.
  - A strobe is accepted when `downsample_2x_i`=0, or when `skip`=0 before the flip.
  - `skip` is cleared whenever `downsample_2x_i`=0.
  - An accepted strobe writes pending and sets it full.
  - If pending was already full and not being consumed in the same cycle, `OVERFLOW_o` pulses. The newest data wins.
- **Simultaneous accept and frame start**: active takes the old pending. The new pair goes into pending, which stays full. No overflow is flagged.

## Timing
- Reset state: `ph`=0, `b`=63, pending empty, active=0, `skip`=0. All outputs are 0.
- First tick after reset is a frame start: `ph` wraps after 2·`BCK_HALF` cycles, so the first frame begins at cycle 2·`BCK_HALF` after reset release. That frame sends zeros and pulses `UNDERFLOW_o` unless a pair was accepted first.
- Latency: an accepted pair goes out in the next frame. Its left MSB is on `I2S_DATA` from the frame-start tick.
- Reset mid-frame returns everything to the reset state on the next edge. No partial frame is completed.
- Sample rate = AMCLK / (128·`BCK_HALF`). With the defaults at 24.576 MHz this is 48 kHz.

## Structure
- Shared audio package holds:
  - `I2S_SLOT_BITS`=32;
  - `I2S_FRAME_BITS`=64;
  - a stereo sample struct (left, right).
- One natural sub-module, `i2s_bck_gen`: the phase counter and BCK generation. It outputs `I2S_BCK` and a tick strobe.
- Buffering, shifting and flags stay in the top level.

## Test plan
- **Single pair**: reset, then strobe L=0x800001, R=0x7FFFFE before the first frame start. Capture first frame:
  - left slot = 1000…0001, 8 zeros;
  - right slot = 0111…1110, 8 zeros;
  - WS falls one BCK before left MSB;
  - no flags.
- **Underflow**: no strobe for a frame after one pair. The same pair is retransmitted and `UNDERFLOW_o` pulses exactly once at that frame start.
- **Overflow**: two strobes (A, then B) within one frame. `OVERFLOW_o` pulses on B, and the next frame carries B.
- **Decimation**: `downsample_2x_i`=1 and strobes with values 1, 2, 3, 4, one per frame. Transmitted left values are 1, 1, 3, 3.
- **Collision**: strobe in the exact frame-start cycle. Old pending goes out, the new pair goes out next frame, and there is no overflow.
- **Reset mid-frame**: assert `ARST_i` at `b`=40 for one cycle. All outputs are 0 on the next edge, and the frame restarts 2·`BCK_HALF` cycles after release.
